// File: rtl/mips_state_machine.sv
// Top-level sequencing FSM for the multi-cycle MIPS core.
// Steps FETCH -> EXEC1 -> (EXEC2) -> FETCH, stalls on waitrequest, and parks in HALT.
//
// state | meaning
// FETCH | instruction fetch from memory
// EXEC1 | first execute cycle; extra selects EXEC2 or return to FETCH
// EXEC2 | second execute cycle for multi-cycle instructions
// HALT  | absorbing stop state; left only via rst with halt low
module mips_state_machine (
  input  logic       clk,
  input  logic       rst,
  input  logic       halt,
  input  logic       extra,
  input  logic       waitrequest,
  output logic [1:0] s
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC1 = 2'b01,
    EXEC2 = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t state, state_next;

  // halt outranks rst, so a simultaneous halt and reset lands in HALT.
  always_ff @(posedge clk) begin
    if (halt) begin
      state <= HALT;
    end else if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (!waitrequest) state_next = EXEC1;
      end
      EXEC1: begin
        if (!waitrequest) state_next = extra ? EXEC2 : FETCH;
      end
      EXEC2: begin
        if (!waitrequest) state_next = FETCH;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  assign s = state;

endmodule

// File: tb/tb_mips_state_machine.sv
// Scoreboard bench for mips_state_machine: the driver queues the state expected
// after each edge, and a monitor compares the DUT output just after that edge.
module tb_mips_state_machine;

  localparam logic [1:0] S_FETCH = 2'b00;
  localparam logic [1:0] S_EXEC1 = 2'b01;
  localparam logic [1:0] S_EXEC2 = 2'b10;
  localparam logic [1:0] S_HALT  = 2'b11;

  typedef struct {
    logic [1:0] exp_s;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       halt;
  logic       extra;
  logic       waitrequest;
  logic [1:0] s;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  mips_state_machine dut (
    .clk         (clk),
    .rst         (rst),
    .halt        (halt),
    .extra       (extra),
    .waitrequest (waitrequest),
    .s           (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the expected state after the next rising edge is queued.
  task automatic step(input logic r, input logic h, input logic x, input logic w,
                      input logic [1:0] e, input string nm);
    exp_t item;
    @(negedge clk);
    rst         = r;
    halt        = h;
    extra       = x;
    waitrequest = w;
    item.exp_s  = e;
    item.name   = nm;
    exp_q.push_back(item);
  endtask

  initial begin : monitor
    exp_t item;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        item = exp_q.pop_front();
        checks++;
        if (s !== item.exp_s) begin
          failures++;
          $display("FAIL %s: s=%b expected=%b", item.name, s, item.exp_s);
        end
      end
    end
  end

  initial begin : driver
    int budget;
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    halt        = 1'b0;
    extra       = 1'b0;
    waitrequest = 1'b0;

    // reset, then reset again from EXEC1
    step(1, 0, 0, 0, S_FETCH, "reset_initial");
    step(0, 0, 0, 0, S_EXEC1, "fetch_to_exec1");
    step(1, 0, 0, 0, S_FETCH, "reset_from_exec1");
    step(1, 0, 0, 0, S_FETCH, "reset_held");
    // two-cycle instructions
    step(0, 0, 0, 0, S_EXEC1, "two_cyc_exec1_a");
    step(0, 0, 0, 0, S_FETCH, "two_cyc_fetch_a");
    step(0, 0, 0, 0, S_EXEC1, "two_cyc_exec1_b");
    step(0, 0, 0, 0, S_FETCH, "two_cyc_fetch_b");
    // extra is sampled when leaving EXEC1, not when entering it
    step(0, 0, 1, 0, S_EXEC1, "extra_on_entry");
    step(0, 0, 0, 0, S_FETCH, "extra_low_on_exit");
    // three-cycle instructions; extra ignored in EXEC2
    step(0, 0, 0, 0, S_EXEC1, "three_cyc_exec1_a");
    step(0, 0, 1, 0, S_EXEC2, "three_cyc_exec2_a");
    step(0, 0, 0, 0, S_FETCH, "exec2_extra0_fetch");
    step(0, 0, 0, 0, S_EXEC1, "three_cyc_exec1_b");
    step(0, 0, 1, 0, S_EXEC2, "three_cyc_exec2_b");
    step(0, 0, 1, 0, S_FETCH, "exec2_extra1_fetch");
    // stalls in each running state
    step(0, 0, 0, 1, S_FETCH, "fetch_stall_1");
    step(0, 0, 0, 1, S_FETCH, "fetch_stall_2");
    step(0, 0, 0, 0, S_EXEC1, "fetch_stall_release");
    step(0, 0, 1, 1, S_EXEC1, "exec1_stall_1");
    step(0, 0, 1, 1, S_EXEC1, "exec1_stall_2");
    step(0, 0, 1, 0, S_EXEC2, "exec1_stall_release");
    step(0, 0, 0, 1, S_EXEC2, "exec2_stall_1");
    step(0, 0, 0, 1, S_EXEC2, "exec2_stall_2");
    step(0, 0, 0, 1, S_EXEC2, "exec2_stall_3");
    step(0, 0, 0, 0, S_FETCH, "exec2_stall_release");
    // halt behaviour
    step(0, 0, 0, 0, S_EXEC1, "pre_halt_exec1");
    step(0, 1, 0, 0, S_HALT,  "halt_from_exec1");
    step(0, 0, 0, 0, S_HALT,  "halt_dropped_1");
    step(0, 0, 1, 0, S_HALT,  "halt_dropped_2");
    step(0, 0, 0, 1, S_HALT,  "halt_with_wait");
    step(1, 1, 0, 0, S_HALT,  "halt_and_rst");
    step(1, 0, 0, 0, S_FETCH, "rst_exits_halt");
    step(0, 1, 0, 0, S_HALT,  "halt_from_fetch");
    step(1, 0, 0, 0, S_FETCH, "rst_exits_halt_2");
    // priority corners
    step(0, 0, 0, 0, S_EXEC1, "corner_exec1");
    step(0, 1, 1, 1, S_HALT,  "halt_over_wait");
    step(1, 0, 0, 0, S_FETCH, "corner_reset");
    step(0, 0, 0, 0, S_EXEC1, "corner_exec1_b");
    step(0, 0, 1, 0, S_EXEC2, "corner_exec2");
    step(1, 0, 0, 1, S_FETCH, "rst_over_wait_exec2");
    step(1, 1, 1, 1, S_HALT,  "halt_over_all");
    step(1, 0, 0, 0, S_FETCH, "final_reset");

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
